// File: rtl/upc_pkg.sv
// Shared types for the micro-program sequencer: sequencing opcodes and FSM states.
package upc_pkg;

    localparam int unsigned UPC_W = 5;

    typedef enum logic [2:0] {
        NEXT = 3'b000,
        JUMP = 3'b001,
        BRT  = 3'b010,
        BRF  = 3'b011,
        CALL = 3'b100,
        RET  = 3'b101,
        WAIT = 3'b110,
        END  = 3'b111
    } seq_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } useq_state_e;

endpackage

// File: rtl/upc_ret_stack.sv
// LIFO of micro-subroutine return addresses; dout always shows the top entry.
module upc_ret_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned SP_W = $clog2(DEPTH + 1);
    localparam int unsigned IX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp;

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);
    assign dout  = empty ? '0 : mem[IX_W'(sp - SP_W'(1))];

    // Push wins over pop; overflow/underflow requests are dropped here as a backstop.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            mem[IX_W'(sp)] <= din;
            sp             <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/upc_sequencer.sv
// Next-address logic for the micro-PC register. Define UPC_STACK_EN to build the
// return stack; without it CALL acts as JUMP and RET is a fault.
module upc_sequencer #(
    parameter int unsigned UPC_W       = upc_pkg::UPC_W,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [UPC_W-1:0] upc,
    input  logic [2:0]       seq_op,
    input  logic [UPC_W-1:0] seq_addr,
    input  logic [1:0]       cond_sel,
    input  logic [3:0]       cond,
    output logic [UPC_W-1:0] upc_next,
    output logic             load_incr,
    output logic             busy,
    output logic             done,
    output logic             stack_err
);

    import upc_pkg::*;

    if (STACK_DEPTH < 1 || STACK_DEPTH > 8) begin : g_bad_depth
        $error("upc_sequencer: STACK_DEPTH must be 1..8");
    end

    useq_state_e      state, state_next;
    seq_op_e          op;
    logic             c;
    logic             stack_fault_c;
    logic [UPC_W-1:0] inc;

    assign op  = seq_op_e'(seq_op);
    assign c   = cond[cond_sel];
    assign inc = upc + UPC_W'(1);

`ifdef UPC_STACK_EN
    logic             push, pop, stk_full, stk_empty;
    logic [UPC_W-1:0] ret_addr;

    assign push = (state == RUN) && (op == CALL) && !stk_full;
    assign pop  = (state == RUN) && (op == RET) && !stk_empty;
    assign stack_fault_c = ((op == CALL) && stk_full) || ((op == RET) && stk_empty);

    upc_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (UPC_W)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (inc),
        .dout  (ret_addr),
        .full  (stk_full),
        .empty (stk_empty)
    );
`else
    assign stack_fault_c = (op == RET);
`endif

    // State register plus the registered end-of-program pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == RUN) && (op == END) && !stack_fault_c;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                if (stack_fault_c)   state_next = ERR;
                else if (op == END)  state_next = IDLE;
            end
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    // Outside RUN the upc is parked at 0 (IDLE) or frozen (ERR).
    always_comb begin
        upc_next  = '0;
        load_incr = 1'b1;
        busy      = (state == RUN);
        stack_err = (state == ERR);
        case (state)
            RUN: begin
                case (op)
                    NEXT: load_incr = 1'b0;
                    JUMP: upc_next  = seq_addr;
                    BRT:  if (c)  upc_next = seq_addr; else load_incr = 1'b0;
                    BRF:  if (!c) upc_next = seq_addr; else load_incr = 1'b0;
`ifdef UPC_STACK_EN
                    CALL: upc_next  = stk_full ? upc : seq_addr;
                    RET:  upc_next  = stk_empty ? upc : ret_addr;
`else
                    CALL: upc_next  = seq_addr;
                    RET:  upc_next  = upc;
`endif
                    WAIT: if (c)  load_incr = 1'b0; else upc_next = upc;
                    END:  upc_next  = '0;
                    default: upc_next = '0;
                endcase
            end
            ERR:     upc_next = upc;
            default: upc_next = '0;
        endcase
    end

endmodule
